// File: rtl/mul_share_arb.sv
// -----------------------------------------------------------------------------
// mul_share_arb
//
// Shares one sequential multiplier between N_REQ requesters. One operand pair is
// accepted at a time (round-robin winner), registered onto mul_a/mul_b, handed
// to the multiplier over its src handshake, and the product is captured from the
// dest handshake and returned to the requester that owns the operation.
//
// Parameters
//   N_REQ  number of requesters (2..8)
//   WIDTH  operand width; product is 2*WIDTH, passed through unmodified
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   req_val/ready   per-requester operand handshake (req_ready one-hot or zero)
//   req_a/req_b     flattened operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_val/ready   per-requester result handshake (rsp_val one-hot or zero)
//   rsp_data        shared result bus, valid where rsp_val is set
//   mul_src_*       operand handshake towards the multiplier, mul_a/mul_b
//   mul_dest_*      product handshake from the multiplier, mul_product
//
// Configuration macro
//   MUL_SHARE_ARB_FIXED_PRIO_EN  when defined, lowest index always wins and the
//                                round-robin pointer is held at zero.
// -----------------------------------------------------------------------------
module mul_share_arb #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_val,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         rsp_val,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_data,
    output logic                     mul_src_val,
    input  logic                     mul_src_ready,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic                     mul_dest_val,
    output logic                     mul_dest_ready,
    input  logic [2*WIDTH-1:0]       mul_product
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(N_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [WIDTH-1:0]   a_arr [N_REQ];
    logic [WIDTH-1:0]   b_arr [N_REQ];

    // Unpack the flattened operand buses so the winner can index them directly.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
        assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end

    // Winner search: rotate req_val so rr_ptr sits at bit 0, pick the lowest set
    // bit of the rotated vector, then add rr_ptr back modulo N_REQ.
    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] req_rot;
    logic [PTR_W-1:0]   offset;
    logic [PTR_W:0]     win_sum;
    logic [PTR_W-1:0]   winner;
    logic               found;
    logic               grant;

    assign req_dbl = {req_val, req_val};
    assign req_rot = req_dbl >> rr_ptr_q;

    always_comb begin
        found   = 1'b0;
        offset  = '0;
        win_sum = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found  = 1'b1;
                offset = PTR_W'(k);
            end
        end
        win_sum = {1'b0, rr_ptr_q} + {1'b0, offset};
        if (win_sum >= NREQ_W) begin
            win_sum = win_sum - NREQ_W;
        end
        winner = win_sum[PTR_W-1:0];
    end

    assign grant = (state_q == S_IDLE) && found;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
        assign req_ready[gi] = grant && (winner == PTR_W'(gi));
        assign rsp_val[gi]   = (state_q == S_RESP) && (owner_q == PTR_W'(gi));
    end

    assign mul_src_val    = (state_q == S_ISSUE);
    assign mul_dest_ready = (state_q == S_WAIT);
    assign mul_a          = mul_a_q;
    assign mul_b          = mul_b_q;
    assign rsp_data       = rsp_data_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    mul_a_d = a_arr[winner];
                    mul_b_d = b_arr[winner];
                    owner_d = winner;
`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
                    rr_ptr_d = '0;
`else
                    rr_ptr_d = (winner == PTR_W'(N_REQ-1)) ? '0 : winner + 1'b1;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mul_src_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mul_dest_val) begin
                    rsp_data_d = mul_product;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                // Only the owner's accept retires the response.
                if (rsp_ready[owner_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_mul_share_arb.sv
// -----------------------------------------------------------------------------
// tb_mul_share_arb
//
// Self-checking bench for mul_share_arb (N_REQ=4, WIDTH=16). Directed scenario
// tasks plus a randomized traffic task whose expectations come from a
// transaction-level model: one operation in flight, round-robin pick over the
// pending requesters, product = signed a*b. The bench also plays the multiplier
// with random stalls and latency. Honors MUL_SHARE_ARB_FIXED_PRIO_EN.
// -----------------------------------------------------------------------------
module tb_mul_share_arb;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_val;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     rsp_val;
    logic [N-1:0]     rsp_ready;
    logic [2*W-1:0]   rsp_data;
    logic             mul_src_val;
    logic             mul_src_ready;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic             mul_dest_val;
    logic             mul_dest_ready;
    logic [2*W-1:0]   mul_product;

    int n_cmp = 0;
    int n_err = 0;
    int grant_q[$];

    mul_share_arb #(.N_REQ(N), .WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_val        (req_val),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .rsp_val        (rsp_val),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .mul_src_val    (mul_src_val),
        .mul_src_ready  (mul_src_ready),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_dest_val   (mul_dest_val),
        .mul_dest_ready (mul_dest_ready),
        .mul_product    (mul_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arbitration rule: first pending index at or after ptr, wrapping.
    function automatic int exp_pick(input logic [N-1:0] m, input int ptr);
`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (m[i]) return i;
`else
        for (int k = 0; k < N; k++) if (m[(ptr + k) % N]) return (ptr + k) % N;
`endif
        return -1;
    endfunction

    function automatic int next_ptr(input int win);
`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (win + 1) % N;
`endif
    endfunction

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_val = '0; req_a = '0; req_b = '0; rsp_ready = '0;
        mul_src_ready = 1'b0; mul_dest_val = 1'b0; mul_product = '0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    // Plays the multiplier and the requester's result side for an operation
    // that was accepted on the previous edge; returns what RESP presented.
    task automatic complete_op(input int stall, input int lat, input int bp,
                               output logic [2*W-1:0] d, output logic [N-1:0] v);
        mul_src_ready = 1'b0;
        repeat (stall) cyc();
        mul_src_ready = 1'b1;
        cyc();
        mul_src_ready = 1'b0;
        repeat (lat) cyc();
        mul_dest_val = 1'b1;
        mul_product  = smul(mul_a, mul_b);
        cyc();
        mul_dest_val = 1'b0;
        repeat (bp) cyc();
        #1;
        d = rsp_data;
        v = rsp_val;
        rsp_ready = '1;
        cyc();
        rsp_ready = '0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if ({req_ready, rsp_val, mul_src_val, mul_dest_ready, mul_a, mul_b, rsp_data} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rr=%b rv=%b sv=%b dr=%b a=%h b=%h d=%h, want all 0",
                     req_ready, rsp_val, mul_src_val, mul_dest_ready, mul_a, mul_b, rsp_data);
        end
    endtask

    task automatic test_single();
        logic [2*W-1:0] d;
        logic [N-1:0]   v;
        do_reset();
        req_val = 4'b0010;
        req_a[1*W +: W] = 16'd7;
        req_b[1*W +: W] = 16'hFFFD;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010 || mul_src_val !== 1'b0) begin
            n_err++;
            $display("FAIL single_grant: got rr=%b sv=%b, want 0010 0", req_ready, mul_src_val);
        end
        cyc();
        req_val = '0;
        #1;
        n_cmp++;
        if ({mul_src_val, mul_a, mul_b, req_ready} !== {1'b1, 16'd7, 16'hFFFD, 4'b0000}) begin
            n_err++;
            $display("FAIL single_issue: got sv=%b a=%h b=%h rr=%b, want 1 0007 fffd 0000",
                     mul_src_val, mul_a, mul_b, req_ready);
        end
        complete_op(0, 2, 3, d, v);
        n_cmp++;
        if (v !== 4'b0010 || d !== 32'hFFFF_FFEB) begin
            n_err++;
            $display("FAIL single_resp: got rv=%b d=%h, want 0010 ffffffeb", v, d);
        end
        $display("txn single: owner=1 a=0007 b=fffd p=%h", d);
        req_val = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== onehot(exp_pick(4'b0001, next_ptr(1))) || rsp_val !== '0) begin
            n_err++;
            $display("FAIL single_back_idle: got rr=%b rv=%b, want 0001 0000", req_ready, rsp_val);
        end
        cyc();
        req_val = '0;
        complete_op(1, 0, 0, d, v);
    endtask

    task automatic test_wrap();
        logic [2*W-1:0] d;
        logic [N-1:0]   v;
        int ptr;
        int w;
        do_reset();
        req_val = 4'b0100;
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        cyc();
        req_val = '0;
        complete_op(0, 1, 0, d, v);
        ptr = next_ptr(2);
        req_val = 4'b1001;
        #1;
        w = exp_pick(4'b1001, ptr);
        n_cmp++;
        if (req_ready !== onehot(w)) begin
            n_err++;
            $display("FAIL wrap_first: got rr=%b, want %b", req_ready, onehot(w));
        end
        cyc();
        req_val = 4'b1001 & ~onehot(w);
        complete_op(0, 1, 0, d, v);
        n_cmp++;
        if (v !== onehot(w) || d !== smul(req_a[w*W +: W], req_b[w*W +: W])) begin
            n_err++;
            $display("FAIL wrap_first_resp: got rv=%b d=%h, want %b %h", v, d, onehot(w),
                     smul(req_a[w*W +: W], req_b[w*W +: W]));
        end
        $display("txn wrap: owner=%0d p=%h", w, d);
        ptr = next_ptr(w);
        w = exp_pick(req_val, ptr);
        #1;
        n_cmp++;
        if (req_ready !== onehot(w)) begin
            n_err++;
            $display("FAIL wrap_second: got rr=%b, want %b", req_ready, onehot(w));
        end
        cyc();
        req_val = '0;
        complete_op(0, 0, 0, d, v);
        $display("txn wrap: owner=%0d p=%h", w, d);
    endtask

    task automatic test_backpressure();
        logic [2*W-1:0] exp_d;
        logic [2*W-1:0] d;
        logic [N-1:0]   v;
        do_reset();
        req_val = 4'b0100;
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        exp_d = smul(req_a[2*W +: W], req_b[2*W +: W]);
        cyc();
        mul_src_ready = 1'b1;
        cyc();
        mul_src_ready = 1'b0;
        mul_dest_val  = 1'b1;
        mul_product   = smul(mul_a, mul_b);
        cyc();
        mul_dest_val = 1'b0;
        mul_product  = '0;
        // Requester 2 asks again with new operands while its result is held.
        req_a[2*W +: W] = 16'h1234;
        req_b[2*W +: W] = 16'h0002;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_cmp++;
            if (rsp_val !== 4'b0100 || rsp_data !== exp_d || req_ready !== '0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got rv=%b d=%h rr=%b, want 0100 %h 0000",
                         c, rsp_val, rsp_data, req_ready, exp_d);
            end
            cyc();
        end
        $display("txn bp: owner=2 p=%h", exp_d);
        rsp_ready = 4'b0100;
        cyc();
        rsp_ready = '0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100 || rsp_val !== '0) begin
            n_err++;
            $display("FAIL bp_release: got rr=%b rv=%b, want 0100 0000", req_ready, rsp_val);
        end
        cyc();
        req_val = '0;
        complete_op(0, 0, 0, d, v);
        n_cmp++;
        if (d !== 32'h0000_2468) begin
            n_err++;
            $display("FAIL bp_second: got d=%h, want 00002468", d);
        end
        $display("txn bp: owner=2 p=%h", d);
    endtask

    task automatic test_issue_stall();
        logic [W-1:0] a;
        logic [W-1:0] b;
        do_reset();
        a = W'($urandom);
        b = W'($urandom);
        req_val = 4'b0001;
        req_a[0 +: W] = a;
        req_b[0 +: W] = b;
        cyc();
        req_val = '0;
        req_a = '0;
        req_b = '0;
        mul_src_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) mul_src_ready = 1'b1;
            #1;
            n_cmp++;
            if ({mul_src_val, mul_dest_ready, mul_a, mul_b} !== {1'b1, 1'b0, a, b}) begin
                n_err++;
                $display("FAIL stall_issue[%0d]: got sv=%b dr=%b a=%h b=%h, want 1 0 %h %h",
                         c, mul_src_val, mul_dest_ready, mul_a, mul_b, a, b);
            end
            cyc();
        end
        mul_src_ready = 1'b0;
        #1;
        n_cmp++;
        if (mul_src_val !== 1'b0 || mul_dest_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_wait: got sv=%b dr=%b, want 0 1", mul_src_val, mul_dest_ready);
        end
        mul_dest_val = 1'b1;
        mul_product  = smul(mul_a, mul_b);
        cyc();
        mul_dest_val = 1'b0;
        #1;
        n_cmp++;
        if (rsp_val !== 4'b0001 || rsp_data !== smul(a, b)) begin
            n_err++;
            $display("FAIL stall_resp: got rv=%b d=%h, want 0001 %h", rsp_val, rsp_data, smul(a, b));
        end
        $display("txn stall: owner=0 a=%h b=%h p=%h", a, b, rsp_data);
        rsp_ready = 4'b0001;
        cyc();
        rsp_ready = '0;
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] d;
        logic [N-1:0]   v;
        logic [W-1:0]   a0;
        logic [W-1:0]   b0;
        do_reset();
        req_val = 4'b0010;
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        cyc();
        req_val = '0;
        mul_src_ready = 1'b1;
        cyc();
        mul_src_ready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, rsp_val, mul_src_val, mul_dest_ready, mul_a, mul_b, rsp_data} !== '0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got rr=%b rv=%b sv=%b dr=%b a=%h b=%h d=%h, want all 0",
                     req_ready, rsp_val, mul_src_val, mul_dest_ready, mul_a, mul_b, rsp_data);
        end
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1;
            n_cmp++;
            if (rsp_val !== '0 || mul_dest_ready !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_no_resp[%0d]: got rv=%b dr=%b, want 0000 0", c, rsp_val, mul_dest_ready);
            end
        end
        req_val = 4'b1111;
        a0 = W'($urandom);
        b0 = W'($urandom);
        req_a[0 +: W] = a0;
        req_b[0 +: W] = b0;
        #1;
        n_cmp++;
        if (req_ready !== onehot(exp_pick(4'b1111, 0))) begin
            n_err++;
            $display("FAIL rstmid_ptr: got rr=%b, want %b", req_ready, onehot(exp_pick(4'b1111, 0)));
        end
        cyc();
        req_val = '0;
        complete_op(2, 3, 1, d, v);
        n_cmp++;
        if (v !== 4'b0001 || d !== smul(a0, b0)) begin
            n_err++;
            $display("FAIL rstmid_new_op: got rv=%b d=%h, want 0001 %h", v, d, smul(a0, b0));
        end
        $display("txn rstmid: owner=0 p=%h", d);
    endtask

    // Randomized traffic against the transaction-level model.
    task automatic test_traffic(input int n_ops, input int req_pct, input logic [N-1:0] mask);
        logic [N-1:0]   pend;
        logic [W-1:0]   pa [N];
        logic [W-1:0]   pb [N];
        logic [W-1:0]   opa;
        logic [W-1:0]   opb;
        logic [2*W-1:0] exp_p;
        logic [2*W-1:0] mb_prod;
        logic [N-1:0]   exp_rr;
        logic [N-1:0]   exp_rv;
        logic           exp_sv;
        logic           exp_dr;
        logic           outst;
        logic           issued;
        logic           deliv;
        logic           mb_busy;
        int             mb_cnt;
        int             ptr;
        int             owner;
        int             win;
        int             done;
        int             cycles;
        do_reset();
        pend = '0; outst = 0; issued = 0; deliv = 0; mb_busy = 0; mb_cnt = 0;
        ptr = 0; owner = 0; done = 0; cycles = 0; opa = '0; opb = '0; exp_p = '0; mb_prod = '0;
        for (int i = 0; i < N; i++) begin pa[i] = '0; pb[i] = '0; end
        while (done < n_ops && cycles < 8000) begin
            cycles++;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && mask[i] && $urandom_range(99) < req_pct) begin
                    pend[i] = 1'b1;
                    pa[i] = W'($urandom);
                    pb[i] = W'($urandom);
                end
                req_a[i*W +: W] = pa[i];
                req_b[i*W +: W] = pb[i];
            end
            req_val       = pend;
            rsp_ready     = N'($urandom);
            mul_src_ready = !mb_busy && ($urandom_range(3) != 0);
            mul_dest_val  = mb_busy && (mb_cnt == 0);
            mul_product   = mb_prod;
            #1;
            win    = (!outst && pend != '0) ? exp_pick(pend, ptr) : -1;
            exp_rr = onehot(win);
            exp_rv = (outst && deliv) ? onehot(owner) : '0;
            exp_sv = outst && !issued;
            exp_dr = issued && !deliv;
            n_cmp++;
            if ({req_ready, rsp_val, mul_src_val, mul_dest_ready} !== {exp_rr, exp_rv, exp_sv, exp_dr}) begin
                n_err++;
                $display("FAIL traffic_ctrl@%0d: got rr=%b rv=%b sv=%b dr=%b, want %b %b %b %b",
                         cycles, req_ready, rsp_val, mul_src_val, mul_dest_ready,
                         exp_rr, exp_rv, exp_sv, exp_dr);
            end
            if (exp_sv) begin
                n_cmp++;
                if (mul_a !== opa || mul_b !== opb) begin
                    n_err++;
                    $display("FAIL traffic_operands@%0d: got a=%h b=%h, want %h %h",
                             cycles, mul_a, mul_b, opa, opb);
                end
            end
            if (exp_rv != '0) begin
                n_cmp++;
                if (rsp_data !== exp_p) begin
                    n_err++;
                    $display("FAIL traffic_data@%0d: got %h, want %h", cycles, rsp_data, exp_p);
                end
            end
            if (mb_busy && mb_cnt > 0) mb_cnt--;
            if (win >= 0) begin
                outst = 1; issued = 0; deliv = 0; owner = win;
                opa = pa[win]; opb = pb[win]; exp_p = smul(pa[win], pb[win]);
                pend[win] = 1'b0;
                ptr = next_ptr(win);
                grant_q.push_back(win);
            end else if (outst && !issued && mul_src_ready) begin
                issued  = 1;
                mb_busy = 1;
                mb_cnt  = $urandom_range(3);
                mb_prod = smul(mul_a, mul_b);
            end else if (issued && !deliv && mul_dest_val) begin
                deliv   = 1;
                mb_busy = 0;
            end else if (deliv && rsp_ready[owner]) begin
                outst = 0;
                done++;
                $display("txn %0d: owner=%0d a=%h b=%h p=%h", done, owner, opa, opb, exp_p);
            end
            cyc();
        end
        if (done < n_ops) begin
            n_cmp++;
            n_err++;
            $display("FAIL traffic_timeout: completed %0d, want %0d", done, n_ops);
        end
    endtask

    task automatic test_fairness();
        int exp_g;
        grant_q.delete();
        test_traffic(8, 100, 4'b1111);
        for (int i = 0; i < 5; i++) begin
`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = i % N;
`endif
            n_cmp++;
            if (i >= grant_q.size() || grant_q[i] != exp_g) begin
                n_err++;
                $display("FAIL fairness_order[%0d]: got %0d, want %0d", i,
                         (i < grant_q.size()) ? grant_q[i] : -1, exp_g);
            end
        end
    endtask

    task automatic test_random();
        grant_q.delete();
        test_traffic(40, 30, 4'b1111);
        test_traffic(15, 50, 4'b0110);
    endtask

    initial begin
        rst = 1'b1; req_val = '0; req_a = '0; req_b = '0; rsp_ready = '0;
        mul_src_ready = 1'b0; mul_dest_val = 1'b0; mul_product = '0;
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_issue_stall();
        test_reset_mid();
        test_fairness();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter and sequencer that shares one sequential Booth multiplier (val/ready operand and result handshakes) between N_REQ requesters. It sits between the requester ports and the multiplier's src/dest handshake. It accepts one operand pair at a time, drives it into the multiplier, captures the product, and returns it to the granted requester. Only one multiplication is in flight.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- WIDTH, 16: operand width; product is 2*WIDTH, signed.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_val  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept strobe, one-hot or zero.
- req_a  in  N_REQ*WIDTH  flattened multiplicands; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  flattened multipliers, same packing.
- rsp_val  out  N_REQ  per-requester result valid, one-hot or zero.
- rsp_ready  in  N_REQ  per-requester result accept.
- rsp_data  out  2*WIDTH  shared result bus, meaningful where rsp_val is set.
- mul_src_val  out  1  operand valid to multiplier.
- mul_src_ready  in  1  multiplier idle/accepting.
- mul_a, mul_b  out  WIDTH  registered operands to multiplier.
- mul_dest_val  in  1  multiplier product valid.
- mul_dest_ready  out  1  arbiter accepts product.
- mul_product  in  2*WIDTH  multiplier product.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Encoding 2 bits; an illegal state goes to IDLE.
- IDLE:
  - Winner is the first i with req_val[i] set, searching from rr_ptr upward with wrap N_REQ-1 -> 0.
  - req_ready[winner] = 1 combinationally in this cycle.
  - On that edge, latch req_a/req_b of the winner into mul_a/mul_b and latch owner = winner.
  - rr_ptr advances to (winner+1) mod N_REQ. Next state is ISSUE.
  - If no req_val is set, stay in IDLE; rr_ptr holds.
- ISSUE:
  - mul_src_val = 1, with mul_a/mul_b stable.
  - When mul_src_ready = 1, go to WAIT on that edge.
- WAIT:
  - mul_dest_ready = 1.
  - When mul_dest_val = 1, latch mul_product into rsp_data and go to RESP.
- RESP:
  - rsp_val[owner] = 1, and rsp_data is held.
  - When rsp_ready[owner] = 1, go to IDLE.
  - rsp_ready of non-owners is ignored.
- No request is accepted outside IDLE; req_ready = 0 in ISSUE, WAIT and RESP.
- Requesters must hold req_val and their operands until req_ready.
- Product is passed unmodified (signed 2*WIDTH). The arbiter does no arithmetic.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, owner = 0.
  - mul_a = mul_b = 0, rsp_data = 0.
  - All val/ready outputs = 0.
- rst has priority over every transition. Reset mid-operation discards the in-flight operation with no response.
  - The multiplier shares rst and must return to its own idle state in the same cycle.
- Arbiter overhead, excluding multiplier compute:
  - accept -> mul_src_val: 1 cycle.
  - mul_dest_val -> rsp_val: 1 cycle.
  - rsp_ready -> next accept possible: 1 cycle (IDLE).
- Back-to-back: minimum 4 arbiter cycles per operation plus multiplier latency.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep req_val and win later in round-robin order.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,N_REQ-1,0.
- A req_val that rises while the arbiter is in RESP is not visible until IDLE.
- rsp_val is held until accepted, with no timeout.

## Configuration
- MUL_SHARE_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins. rr_ptr is removed (held 0) and never advances.
  - Undefined (default): round-robin as described.

## Test plan
- Single requester, N_REQ=4:
  - Stimulus: req_val=4'b0010, a=16'd7, b=-16'sd3.
  - Response: req_ready=4'b0010 for 1 cycle, then mul_src_val, then rsp_val=4'b0010 with rsp_data=32'hFFFF_FFEB.
  - IDLE is reached after rsp_ready[1].
- All four requesting continuously:
  - Response: grant order 0,1,2,3,0 and each rsp_val only on the owner's bit.
  - With FIXED_PRIO_EN: requester 0 granted every operation.
- Wrap-around:
  - Stimulus: rr_ptr=3 (after a grant to 2), req_val=4'b1001.
  - Response: grant 3, then grant 0.
- Response backpressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles in RESP while req_val=4'b0100.
  - Response: rsp_val and rsp_data are stable, req_ready stays 0, and no grant is made until rsp_ready rises.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during WAIT.
  - Response: next cycle all outputs 0, state IDLE, rr_ptr=0, and no rsp_val for the aborted operation. A new request then completes correctly.
- Multiplier stall in ISSUE:
  - Stimulus: mul_src_ready=0 for 5 cycles.
  - Response: mul_src_val stays 1 with mul_a/mul_b unchanged, and the transition to WAIT occurs on the edge where mul_src_ready=1.
